axis_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that merges N AXI-Stream slave inputs onto one AXI-Stream master output.
- Sits upstream of the stream sink: many producers share one downstream sink channel.
- A grant is held for a whole packet, from the first accepted beat through the beat with tlast.
- The output has one register stage. The block exports one-hot grant and busy status for the bench and for debug.

---
 rtl/axis_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter, N slaves onto one registered master.
// Define AXIS_ARB_PORT_TID_EN to drive axis_m_tid with the granted port index.
module axis_rr_arbiter #(
  parameter int N_PORTS          = 4,
  parameter int WIDTH_AXIS_TDATA = 8,
  parameter int WIDTH_AXIS_TUSER = 8,
  parameter int WIDTH_AXIS_TID   = 8,
  parameter int WIDTH_AXIS_TKEEP = 8
) (
  input  logic                                  axis_m_clk,
  input  logic                                  axis_m_rst,
  input  logic [N_PORTS-1:0]                    axis_s_tvalid,
  input  logic [N_PORTS*WIDTH_AXIS_TDATA-1:0]   axis_s_tdata,
  input  logic [N_PORTS*WIDTH_AXIS_TUSER-1:0]   axis_s_tuser,
  input  logic [N_PORTS*WIDTH_AXIS_TID-1:0]     axis_s_tid,
  input  logic [N_PORTS*WIDTH_AXIS_TKEEP-1:0]   axis_s_tkeep,
  input  logic [N_PORTS-1:0]                    axis_s_tlast,
  output logic [N_PORTS-1:0]                    axis_s_tready,
  output logic                                  axis_m_tvalid,
  output logic [WIDTH_AXIS_TDATA-1:0]           axis_m_tdata,
  output logic [WIDTH_AXIS_TUSER-1:0]           axis_m_tuser,
  output logic [WIDTH_AXIS_TID-1:0]             axis_m_tid,
  output logic [WIDTH_AXIS_TKEEP-1:0]           axis_m_tkeep,
  output logic                                  axis_m_tlast,
  input  logic                                  axis_m_tready,
  output logic [N_PORTS-1:0]                    axis_arb_grant,
  output logic                                  axis_arb_busy
);

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] pick;
  logic          found;
  int            cand;
  logic          rdy;
  logic          load;

  logic [WIDTH_AXIS_TDATA-1:0] td_a [N_PORTS];
  logic [WIDTH_AXIS_TUSER-1:0] tu_a [N_PORTS];
  logic [WIDTH_AXIS_TID-1:0]   ti_a [N_PORTS];
  logic [WIDTH_AXIS_TKEEP-1:0] tk_a [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_slice
    assign td_a[i] = axis_s_tdata[i*WIDTH_AXIS_TDATA +: WIDTH_AXIS_TDATA];
    assign tu_a[i] = axis_s_tuser[i*WIDTH_AXIS_TUSER +: WIDTH_AXIS_TUSER];
    assign ti_a[i] = axis_s_tid[i*WIDTH_AXIS_TID +: WIDTH_AXIS_TID];
    assign tk_a[i] = axis_s_tkeep[i*WIDTH_AXIS_TKEEP +: WIDTH_AXIS_TKEEP];
  end

  // Search wraps by subtraction so non-power-of-two N never truncates
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = int'(last_q) + i + 1;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      if (!found && axis_s_tvalid[IW'(cand)]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    axis_s_tready  = '0;
    axis_arb_grant = '0;
    axis_arb_busy  = 1'b0;
    load           = 1'b0;
    rdy            = ~axis_m_tvalid | axis_m_tready;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = pick;
          last_d  = pick;
        end
      end
      BUSY: begin
        axis_arb_busy         = 1'b1;
        axis_arb_grant[gnt_q] = 1'b1;
        axis_s_tready[gnt_q]  = rdy;
        load = axis_s_tvalid[gnt_q] & rdy;
        if (load && axis_s_tlast[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_m_clk) begin
    if (axis_m_rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      last_q        <= IW'(N_PORTS - 1);
      axis_m_tvalid <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      if (load)               axis_m_tvalid <= 1'b1;
      else if (axis_m_tready) axis_m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge axis_m_clk) begin
    if (load) begin
      axis_m_tdata <= td_a[gnt_q];
      axis_m_tuser <= tu_a[gnt_q];
      axis_m_tkeep <= tk_a[gnt_q];
      axis_m_tlast <= axis_s_tlast[gnt_q];
`ifdef AXIS_ARB_PORT_TID_EN
      axis_m_tid   <= WIDTH_AXIS_TID'(gnt_q);
`else
      axis_m_tid   <= ti_a[gnt_q];
`endif
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, packets, round-robin,
// lockout, backpressure, mid-packet reset and tid source.
module tb_axis_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_tvalid;
  logic [3:0] s_tlast;
  logic [7:0] td [4];
  logic [7:0] tu [4];
  logic [7:0] ti [4];
  logic [7:0] tk [4];
  logic [3:0] s_tready;
  logic       m_tvalid;
  logic [7:0] m_tdata, m_tuser, m_tid, m_tkeep;
  logic       m_tlast;
  logic       m_tready;
  logic [3:0] grant;
  logic       busy;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  axis_rr_arbiter dut (
    .axis_m_clk    (clk),
    .axis_m_rst    (rst),
    .axis_s_tvalid (s_tvalid),
    .axis_s_tdata  ({td[3], td[2], td[1], td[0]}),
    .axis_s_tuser  ({tu[3], tu[2], tu[1], tu[0]}),
    .axis_s_tid    ({ti[3], ti[2], ti[1], ti[0]}),
    .axis_s_tkeep  ({tk[3], tk[2], tk[1], tk[0]}),
    .axis_s_tlast  (s_tlast),
    .axis_s_tready (s_tready),
    .axis_m_tvalid (m_tvalid),
    .axis_m_tdata  (m_tdata),
    .axis_m_tuser  (m_tuser),
    .axis_m_tid    (m_tid),
    .axis_m_tkeep  (m_tkeep),
    .axis_m_tlast  (m_tlast),
    .axis_m_tready (m_tready),
    .axis_arb_grant(grant),
    .axis_arb_busy (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      td[i] = '0; tu[i] = '0; ti[i] = '0; tk[i] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    vec++;
    if (m_tvalid !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 ||
        s_tready !== 4'b0) begin
      errs++;
      $display("FAIL reset: tvalid=%b grant=%b busy=%b tready=%b want 0/0000/0/0000",
               m_tvalid, grant, busy, s_tready);
    end
  endtask

  task automatic test_basic();
    reset_dut();
    s_tvalid[0] = 1'b1;
    td[0] = 8'h11;
    tick();
    vec++;
    if (grant !== 4'b0001 || busy !== 1'b1 || s_tready !== 4'b0001 ||
        m_tvalid !== 1'b0) begin
      errs++;
      $display("FAIL basic_grant: grant=%b busy=%b tready=%b tvalid=%b want 0001/1/0001/0",
               grant, busy, s_tready, m_tvalid);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      vec++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h11 + 8'(b) ||
          m_tlast !== (b == 2)) begin
        errs++;
        $display("FAIL basic_beat%0d: valid=%b data=%h last=%b want 1/%h/%b",
                 b, m_tvalid, m_tdata, m_tlast, 8'h11 + 8'(b), b == 2);
      end
      td[0] = 8'h12 + 8'(b);
      s_tlast[0] = (b == 1);
      if (b == 2) s_tvalid[0] = 1'b0;
    end
    vec++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      errs++;
      $display("FAIL basic_idle: busy=%b grant=%b want 0/0000", busy, grant);
    end
    tick();
    vec++;
    if (m_tvalid !== 1'b0) begin
      errs++;
      $display("FAIL basic_drain: tvalid=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    reset_dut();
    s_tvalid = 4'b1111;
    s_tlast  = 4'b1111;
    for (int i = 0; i < 4; i++) td[i] = 8'hA0 + 8'(i);
    for (int k = 0; k < 6; k++) begin
      eg = 4'b0001 << (k % 4);
      tick();
      vec++;
      if (grant !== eg || busy !== 1'b1) begin
        errs++;
        $display("FAIL rr_grant%0d: grant=%b busy=%b want %b/1", k, grant, busy, eg);
      end
      tick();
      vec++;
      if (busy !== 1'b0 || m_tvalid !== 1'b1 || m_tlast !== 1'b1 ||
          m_tdata !== 8'hA0 + 8'(k % 4)) begin
        errs++;
        $display("FAIL rr_beat%0d: busy=%b valid=%b last=%b data=%h want 0/1/1/%h",
                 k, busy, m_tvalid, m_tlast, m_tdata, 8'hA0 + 8'(k % 4));
      end
    end
    s_tvalid = '0;
    tick();
  endtask

  task automatic test_lockout();
    reset_dut();
    s_tvalid[2] = 1'b1;
    td[2] = 8'h20;
    tick();
    s_tvalid[1] = 1'b1;
    s_tlast[1]  = 1'b1;
    td[1] = 8'h31;
    vec++;
    if (grant !== 4'b0100 || s_tready !== 4'b0100) begin
      errs++;
      $display("FAIL lock_grant: grant=%b tready=%b want 0100/0100", grant, s_tready);
    end
    tick();
    s_tvalid[2] = 1'b0;
    vec++;
    if (m_tdata !== 8'h20 || s_tready !== 4'b0100) begin
      errs++;
      $display("FAIL lock_beat0: data=%h tready=%b want 20/0100", m_tdata, s_tready);
    end
    tick();
    vec++;
    if (m_tvalid !== 1'b0 || busy !== 1'b1 || grant !== 4'b0100 ||
        s_tready !== 4'b0100) begin
      errs++;
      $display("FAIL lock_gap: valid=%b busy=%b grant=%b tready=%b want 0/1/0100/0100",
               m_tvalid, busy, grant, s_tready);
    end
    s_tvalid[2] = 1'b1;
    s_tlast[2]  = 1'b1;
    td[2] = 8'h21;
    tick();
    s_tvalid[2] = 1'b0;
    vec++;
    if (m_tdata !== 8'h21 || m_tlast !== 1'b1 || busy !== 1'b0 ||
        s_tready !== 4'b0) begin
      errs++;
      $display("FAIL lock_last: data=%h last=%b busy=%b tready=%b want 21/1/0/0000",
               m_tdata, m_tlast, busy, s_tready);
    end
    tick();
    vec++;
    if (grant !== 4'b0010 || s_tready !== 4'b0010) begin
      errs++;
      $display("FAIL lock_next: grant=%b tready=%b want 0010/0010", grant, s_tready);
    end
    tick();
    s_tvalid[1] = 1'b0;
    vec++;
    if (m_tdata !== 8'h31 || m_tvalid !== 1'b1) begin
      errs++;
      $display("FAIL lock_p1: data=%h valid=%b want 31/1", m_tdata, m_tvalid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    reset_dut();
    s_tvalid[0] = 1'b1;
    td[0] = 8'h40;
    tick();
    tick();
    td[0] = 8'h41;
    vec++;
    if (m_tdata !== 8'h40 || s_tready !== 4'b0001) begin
      errs++;
      $display("FAIL bp_b0: data=%h tready=%b want 40/0001", m_tdata, s_tready);
    end
    tick();
    td[0] = 8'h42;
    m_tready = 1'b0;
    #1;
    vec++;
    if (m_tdata !== 8'h41 || s_tready !== 4'b0000) begin
      errs++;
      $display("FAIL bp_b1: data=%h tready=%b want 41/0000", m_tdata, s_tready);
    end
    for (int s = 0; s < 2; s++) begin
      tick();
      vec++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h41 || s_tready !== 4'b0) begin
        errs++;
        $display("FAIL bp_stall%0d: valid=%b data=%h tready=%b want 1/41/0000",
                 s, m_tvalid, m_tdata, s_tready);
      end
    end
    m_tready = 1'b1;
    #1;
    vec++;
    if (s_tready !== 4'b0001) begin
      errs++;
      $display("FAIL bp_release: tready=%b want 0001", s_tready);
    end
    tick();
    td[0] = 8'h43;
    s_tlast[0] = 1'b1;
    vec++;
    if (m_tdata !== 8'h42 || m_tvalid !== 1'b1) begin
      errs++;
      $display("FAIL bp_b2: data=%h valid=%b want 42/1", m_tdata, m_tvalid);
    end
    tick();
    s_tvalid[0] = 1'b0;
    vec++;
    if (m_tdata !== 8'h43 || m_tlast !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL bp_b3: data=%h last=%b busy=%b want 43/1/0", m_tdata, m_tlast, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    s_tvalid[0] = 1'b1;
    td[0] = 8'h50;
    tick();
    tick();
    td[0] = 8'h51;
    rst = 1'b1;
    tick();
    vec++;
    if (m_tvalid !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rstmid: valid=%b grant=%b busy=%b want 0/0000/0",
               m_tvalid, grant, busy);
    end
    rst = 1'b0;
    s_tvalid = 4'b1001;
    s_tlast  = 4'b1001;
    tick();
    vec++;
    if (grant !== 4'b0001) begin
      errs++;
      $display("FAIL rstmid_prio: grant=%b want 0001", grant);
    end
    tick();
    s_tvalid = '0;
    tick();
  endtask

  task automatic test_tid();
    logic [7:0] exp_tid;
`ifdef AXIS_ARB_PORT_TID_EN
    exp_tid = 8'h03;
`else
    exp_tid = 8'hAA;
`endif
    reset_dut();
    s_tvalid[3] = 1'b1;
    s_tlast[3]  = 1'b1;
    td[3] = 8'h33;
    ti[3] = 8'hAA;
    tu[3] = 8'h5C;
    tk[3] = 8'h0F;
    tick();
    vec++;
    if (grant !== 4'b1000) begin
      errs++;
      $display("FAIL tid_grant: grant=%b want 1000", grant);
    end
    tick();
    s_tvalid[3] = 1'b0;
    vec++;
    if (m_tid !== exp_tid || m_tuser !== 8'h5C || m_tkeep !== 8'h0F ||
        m_tdata !== 8'h33) begin
      errs++;
      $display("FAIL tid_out: tid=%h user=%h keep=%h data=%h want %h/5c/0f/33",
               m_tid, m_tuser, m_tkeep, m_tdata, exp_tid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_lockout();
    test_backpressure();
    test_reset_mid();
    test_tid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
